// File: rtl/mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// mem_access_sequencer
//
// Bus-cycle sequencer feeding the discrete read/write strobe register. It takes
// one CPU load/store at a time, drives the address and write-data buses, and
// produces active-high rd/wr levels framed by address/data setup and hold
// cycles. Read data is captured on the final strobe edge and a one-cycle done
// pulse marks completion.
//
// Optional feature macro: MEM_SEQ_WAIT_EN
//   defined   -> mem_wait stretches the final strobe cycle until memory is ready
//   undefined -> mem_wait is ignored, strobe width is fixed
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   req, we               request strobe and direction (1 = write), IDLE only
//   addr_in, wdata_in     request address and write data
//   mem_wait              memory not-ready (only with MEM_SEQ_WAIT_EN)
//   bus_data_in           data bus from memory
//   busy, done            access in progress / one-cycle completion pulse
//   rdata_out             last captured read data
//   addr_out, data_out    address and write-data buses
//   data_oe               write-data bus drive enable
//   rd, wr                strobe levels to the strobe register
// -----------------------------------------------------------------------------
module mem_access_sequencer #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int SETUP_CYCLES = 1,
  parameter int WAIT_CYCLES  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic                  mem_wait,
  input  logic [DATA_WIDTH-1:0] bus_data_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_oe,
  output logic                  rd,
  output logic                  wr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // The counter counts down to 0, so a phase of N cycles is loaded with N-1.
  localparam logic [3:0] SETUP_LOAD = (SETUP_CYCLES > 0) ? 4'(SETUP_CYCLES - 1) : 4'd0;
  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES);

  state_t                  state_reg, state_next;
  logic [3:0]              count_reg, count_next;
  logic                    we_reg, we_next;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [DATA_WIDTH-1:0]   data_next;
  logic [DATA_WIDTH-1:0]   rdata_next;
  logic                    busy_next, done_next, oe_next, rd_next, wr_next;
  logic                    strobe_last;

`ifdef MEM_SEQ_WAIT_EN
  // Final strobe cycle is stretched while memory reports not-ready.
  assign strobe_last = (count_reg == 4'd0) && !mem_wait;
`else
  logic unused_mem_wait;
  assign unused_mem_wait = mem_wait;
  assign strobe_last     = (count_reg == 4'd0);
`endif

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    we_next    = we_reg;
    addr_next  = addr_out;
    data_next  = data_out;
    rdata_next = rdata_out;

    case (state_reg)
      IDLE: begin
        if (req) begin
          we_next   = we;
          addr_next = addr_in;
          data_next = wdata_in;
          if (SETUP_CYCLES == 0) begin
            state_next = STROBE;
            count_next = WAIT_LOAD;
          end else begin
            state_next = SETUP;
            count_next = SETUP_LOAD;
          end
        end
      end
      SETUP: begin
        if (count_reg == 4'd0) begin
          state_next = STROBE;
          count_next = WAIT_LOAD;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      STROBE: begin
        if (strobe_last) begin
          state_next = HOLD;
          if (!we_reg) begin
            rdata_next = bus_data_in;
          end
        end else if (count_reg != 4'd0) begin
          count_next = count_reg - 4'd1;
        end
      end
      HOLD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are decoded from the upcoming state so they register in step
    // with it; done marks the first IDLE cycle after HOLD.
    busy_next = (state_next != IDLE);
    done_next = (state_reg == HOLD);
    rd_next   = (state_next == STROBE) && !we_next;
    wr_next   = (state_next == STROBE) && we_next;
    oe_next   = (state_next != IDLE) && we_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
      we_reg    <= 1'b0;
      addr_out  <= '0;
      data_out  <= '0;
      rdata_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      data_oe   <= 1'b0;
      rd        <= 1'b0;
      wr        <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      we_reg    <= we_next;
      addr_out  <= addr_next;
      data_out  <= data_next;
      rdata_out <= rdata_next;
      busy      <= busy_next;
      done      <= done_next;
      data_oe   <= oe_next;
      rd        <= rd_next;
      wr        <= wr_next;
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_access_sequencer
//
// Two sequencer instances share the request/bus inputs: "a" uses the default
// timing (setup 1, wait 2) and "b" uses setup 0, wait 0. Each has its own req.
// A vector table drives single accesses and checks latency, strobe widths,
// bus stability and captured data; hand-written sequences cover reset, back-
// to-back requests, ignored requests and reset during a strobe.
// -----------------------------------------------------------------------------
module tb_mem_access_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr_in = 16'h0;
  logic [15:0] wdata_in = 16'h0;
  logic        mem_wait = 1'b0;
  logic [15:0] bus_data_in = 16'h0;

  logic        busy_a, done_a, oe_a, rd_a, wr_a;
  logic [15:0] rdata_a, addr_a, data_a;
  logic        busy_b, done_b, oe_b, rd_b, wr_b;
  logic [15:0] rdata_b, addr_b, data_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_access_sequencer dut_a (
    .clock(clock), .reset(reset), .req(req_a), .we(we),
    .addr_in(addr_in), .wdata_in(wdata_in), .mem_wait(mem_wait),
    .bus_data_in(bus_data_in), .busy(busy_a), .done(done_a),
    .rdata_out(rdata_a), .addr_out(addr_a), .data_out(data_a),
    .data_oe(oe_a), .rd(rd_a), .wr(wr_a)
  );

  mem_access_sequencer #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .SETUP_CYCLES(0), .WAIT_CYCLES(0)
  ) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .we(we),
    .addr_in(addr_in), .wdata_in(wdata_in), .mem_wait(mem_wait),
    .bus_data_in(bus_data_in), .busy(busy_b), .done(done_b),
    .rdata_out(rdata_b), .addr_out(addr_b), .data_out(data_b),
    .data_oe(oe_b), .rd(rd_b), .wr(wr_b)
  );

  typedef struct {
    logic        fast;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] bus;
    logic [15:0] exp_rdata;
    int          wait_start;
    int          wait_len;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    int          exp_oe;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One access from request to done, measured cycle by cycle at negedge.
  task automatic run_vec(input int idx, input vec_t v);
    int lat = 0, nrd = 0, nwr = 0, noe = 0;
    int addr_bad = 0, data_bad = 0, overlap = 0;
    logic s_rd, s_wr, s_oe, s_done, s_busy;
    logic [15:0] s_addr, s_data, s_rdata;
    s_busy = 1'b1;
    s_rdata = 16'h0;
    @(posedge clock); #1;
    we = v.we; addr_in = v.addr; wdata_in = v.wdata; bus_data_in = v.bus;
    if (v.fast) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clock); #1;
    req_a = 1'b0; req_b = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      mem_wait = (v.wait_len > 0) && (n >= v.wait_start) && (n < v.wait_start + v.wait_len);
      @(negedge clock);
      s_rd    = v.fast ? rd_b    : rd_a;
      s_wr    = v.fast ? wr_b    : wr_a;
      s_oe    = v.fast ? oe_b    : oe_a;
      s_done  = v.fast ? done_b  : done_a;
      s_busy  = v.fast ? busy_b  : busy_a;
      s_addr  = v.fast ? addr_b  : addr_a;
      s_data  = v.fast ? data_b  : data_a;
      s_rdata = v.fast ? rdata_b : rdata_a;
      if (s_rd) nrd++;
      if (s_wr) nwr++;
      if (s_oe) noe++;
      if (s_rd && s_wr) overlap++;
      if (s_addr != v.addr) addr_bad++;
      if (v.we && (s_data != v.wdata)) data_bad++;
      if (s_done) begin
        lat = n;
        break;
      end
      @(posedge clock); #1;
    end
    mem_wait = 1'b0;
    $display("vec %0d: fast=%0d we=%0d addr=%04h latency=%0d rd=%0d wr=%0d oe=%0d rdata=%04h",
             idx, v.fast, v.we, v.addr, lat, nrd, nwr, noe, s_rdata);
    check($sformatf("vec%0d latency", idx), lat, v.exp_lat);
    check($sformatf("vec%0d rd width", idx), nrd, v.exp_rd);
    check($sformatf("vec%0d wr width", idx), nwr, v.exp_wr);
    check($sformatf("vec%0d data_oe cycles", idx), noe, v.exp_oe);
    check($sformatf("vec%0d rd/wr overlap", idx), overlap, 0);
    check($sformatf("vec%0d addr_out stable", idx), addr_bad, 0);
    check($sformatf("vec%0d data_out stable", idx), data_bad, 0);
    check($sformatf("vec%0d rdata_out", idx), s_rdata, v.exp_rdata);
    check($sformatf("vec%0d busy in done cycle", idx), s_busy, 0);
  endtask

  initial begin
    int found, gap, ndone, nact;

    //            fast we  addr      wdata     bus       exp_rdata ws wl lat rd wr oe
    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 16'hBEEF, 0, 0, 6, 3, 0, 0};
    vecs[1] = '{1'b0, 1'b1, 16'h00FF, 16'hA5A5, 16'h0000, 16'hBEEF, 0, 0, 6, 0, 3, 5};
    vecs[2] = '{1'b1, 1'b1, 16'h00FF, 16'hA5A5, 16'h1111, 16'h0000, 0, 0, 3, 0, 1, 2};
    vecs[3] = '{1'b1, 1'b0, 16'h0F0F, 16'h2222, 16'h1357, 16'h1357, 0, 0, 3, 1, 0, 0};
    vecs[4] = '{1'b0, 1'b0, 16'hFFFF, 16'h3333, 16'h0000, 16'h0000, 0, 0, 6, 3, 0, 0};
`ifdef MEM_SEQ_WAIT_EN
    vecs[5] = '{1'b0, 1'b0, 16'h4000, 16'h0000, 16'hCAFE, 16'hCAFE, 4, 4, 10, 7, 0, 0};
`else
    vecs[5] = '{1'b0, 1'b0, 16'h4000, 16'h0000, 16'hCAFE, 16'hCAFE, 4, 4, 6, 3, 0, 0};
`endif
    vecs[6] = '{1'b1, 1'b1, 16'hABCD, 16'h5A5A, 16'h0000, 16'h1357, 0, 0, 3, 0, 1, 2};

    // Power-on reset.
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset busy_a", busy_a, 0);
    check("reset done_a", done_a, 0);
    check("reset rd/wr/oe a", {rd_a, wr_a, oe_a}, 0);
    check("reset addr/data a", {addr_a, data_a}, 0);
    check("reset rdata_a", rdata_a, 0);
    check("reset outputs b", {busy_b, done_b, rd_b, wr_b, oe_b, addr_b, data_b, rdata_b}, 0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset mid-simulation, then ten idle cycles with nothing happening.
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    ndone = 0; nact = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (done_a || done_b) ndone++;
      if (busy_a || rd_a || wr_a || oe_a || busy_b || rd_b || wr_b || oe_b) nact++;
    end
    $display("idle after reset: done=%0d active=%0d rdata_a=%04h", ndone, nact, rdata_a);
    check("idle done count", ndone, 0);
    check("idle activity", nact, 0);
    check("idle rdata_a cleared", rdata_a, 0);
    check("idle addr_a cleared", addr_a, 0);

    // Back-to-back: req held high, second access starts on the done cycle.
    @(posedge clock); #1;
    we = 1'b0; addr_in = 16'h2222; bus_data_in = 16'h1111; req_a = 1'b1;
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (done_a) begin found = 1; break; end
    end
    check("b2b first done", found, 1);
    gap = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      gap++;
      if (n == 1) check("b2b busy after done", busy_a, 1);
      if (done_a) break;
    end
    req_a = 1'b0;
    $display("back-to-back: done gap=%0d", gap);
    check("b2b done spacing", gap, 6);
    repeat (3) @(negedge clock);
    check("b2b stops when req drops", busy_a, 0);

    // Request pulse during STROBE must be ignored.
    @(posedge clock); #1;
    we = 1'b0; addr_in = 16'h3333; bus_data_in = 16'h7777; req_a = 1'b1;
    @(posedge clock); #1; req_a = 1'b0;
    @(posedge clock); #1; req_a = 1'b1;
    @(posedge clock); #1; req_a = 1'b0;
    ndone = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clock);
      if (done_a) ndone++;
    end
    $display("ignored req: done count=%0d rdata_a=%04h busy=%0d", ndone, rdata_a, busy_a);
    check("ignored req done count", ndone, 1);
    check("ignored req rdata", rdata_a, 16'h7777);
    check("ignored req idle after", busy_a, 0);

    // Reset during STROBE of a read.
    @(posedge clock); #1;
    we = 1'b0; addr_in = 16'h5555; bus_data_in = 16'h9999; req_a = 1'b1;
    @(posedge clock); #1; req_a = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check("abort rd before reset", rd_a, 1);
    #2 reset = 1'b1;
    #1;
    check("abort rd async drop", rd_a, 0);
    check("abort busy async drop", busy_a, 0);
    check("abort addr cleared", addr_a, 0);
    @(negedge clock); reset = 1'b0;
    ndone = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (done_a) ndone++;
    end
    $display("abort: done count after reset=%0d", ndone);
    check("abort no done", ndone, 0);
    run_vec(7, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
